wb_xbar_rr: RTL



---
 rtl/wb_xbar_rr.sv | 117 +++++++++++
 1 files changed

// File: rtl/wb_xbar_rr.sv
// wb_xbar_rr: NM x NS WISHBONE crossbar with per-slave round-robin arbitration,
// a registered illegal-address error and a per-slave stall watchdog.
module wb_xbar_rr #(
   parameter int NM      = 2,
   parameter int NS      = 12,
   parameter int SEL_W   = 4,
   parameter int SADR_W  = 3,
   parameter int DAT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NM-1:0]              m_cyc_i,
   input  logic [NM-1:0]              m_stb_i,
   input  logic [NM-1:0]              m_we_i,
   input  logic [NM*(SEL_W+SADR_W)-1:0] m_adr_i,
   input  logic [NM*DAT_W-1:0]        m_dat_i,
   output logic [NM*DAT_W-1:0]        m_dat_o,
   output logic [NM-1:0]              m_ack_o,
   output logic [NM-1:0]              m_err_o,
   output logic [NM-1:0]              m_rty_o,
   output logic [NS-1:0]              s_cyc_o,
   output logic [NS-1:0]              s_stb_o,
   output logic [NS-1:0]              s_we_o,
   output logic [NS*SADR_W-1:0]       s_adr_o,
   output logic [NS*DAT_W-1:0]        s_dat_o,
   input  logic [NS*DAT_W-1:0]        s_dat_i,
   input  logic [NS-1:0]              s_ack_i,
   input  logic [NS-1:0]              s_err_i,
   input  logic [NS-1:0]              s_rty_i,
   output logic [NS-1:0]              timeout_o
);
   localparam int AW = SEL_W + SADR_W;
   localparam int OW = NM > 1 ? $clog2(NM) : 1;
   localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   logic [NS-1:0] own_v, free, o_stb, resp, fire, gnt;
   logic [OW-1:0] own [NS];
   logic [OW-1:0] ptr [NS];
   logic [OW-1:0] win [NS];
   logic [TW-1:0] cnt [NS];
   logic [NM-1:0] owns, ill_sel, ill_err, ill_done;

   function automatic int rr_idx(logic [OW-1:0] p, int k);
      return (int'(p) + k) % NM;
   endfunction

   always_comb begin
      int j;
      j = 0;
      owns = '0;
      for (int s = 0; s < NS; s++)
         for (int m = 0; m < NM; m++)
            if (own_v[s] && own[s] == OW'(m)) owns[m] = 1'b1;
      for (int m = 0; m < NM; m++)
         ill_sel[m] = m_cyc_i[m] && m_stb_i[m] && 32'(m_adr_i[m*AW+SADR_W +: SEL_W]) >= NS;
      m_dat_o = '0;
      m_ack_o = '0;
      m_rty_o = '0;
      m_err_o = ill_err;
      for (int s = 0; s < NS; s++) begin
         free[s]  = !own_v[s] || !m_cyc_i[own[s]];
         o_stb[s] = own_v[s] && m_stb_i[own[s]];
         resp[s]  = s_ack_i[s] || s_err_i[s] || s_rty_i[s];
         // a response in the expiry cycle suppresses the watchdog error
         fire[s]  = TIMEOUT != 0 && o_stb[s] && !resp[s] && cnt[s] == TLIM;
         gnt[s]   = 1'b0;
         win[s]   = ptr[s];
         for (int k = 1; k <= NM; k++) begin
            j = rr_idx(ptr[s], k);
            if (!gnt[s] && m_cyc_i[j] && !owns[j] && m_adr_i[j*AW+SADR_W +: SEL_W] == SEL_W'(s)) begin
               gnt[s] = 1'b1;
               win[s] = OW'(j);
            end
         end
         s_cyc_o[s] = own_v[s];
         s_stb_o[s] = o_stb[s];
         s_we_o[s]  = own_v[s] && m_we_i[own[s]];
         s_adr_o[s*SADR_W +: SADR_W] = own_v[s] ? m_adr_i[int'(own[s])*AW +: SADR_W] : '0;
         s_dat_o[s*DAT_W +: DAT_W]   = own_v[s] ? m_dat_i[int'(own[s])*DAT_W +: DAT_W] : '0;
         if (own_v[s]) begin
            m_dat_o[int'(own[s])*DAT_W +: DAT_W] = s_dat_i[s*DAT_W +: DAT_W];
            m_ack_o[own[s]] = s_ack_i[s];
            m_rty_o[own[s]] = s_rty_i[s];
            m_err_o[own[s]] = m_err_o[own[s]] | s_err_i[s] | fire[s];
         end
      end
      timeout_o = fire;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         own_v    <= '0;
         ill_err  <= '0;
         ill_done <= '0;
         for (int s = 0; s < NS; s++) begin
            own[s] <= '0;
            ptr[s] <= OW'(NM - 1);
            cnt[s] <= '0;
         end
      end else begin
         ill_err  <= ill_sel & ~ill_done;
         ill_done <= m_stb_i & (ill_done | ill_sel);
         for (int s = 0; s < NS; s++) begin
            if (free[s]) begin
               own_v[s] <= gnt[s];
               if (gnt[s]) begin
                  own[s] <= win[s];
                  ptr[s] <= win[s];
               end
            end
            cnt[s] <= (free[s] || !o_stb[s] || resp[s] || fire[s]) ? '0 : cnt[s] + 1'b1;
         end
      end
   end
endmodule
